uart_word_loader: RTL

- Parametrised successor to the UART terminal front end: drains bytes from the UART receive FIFO and assembles them into WORD_W-bit words.
- Writes DEPTH consecutive words into processor instruction/data memory starting at address 0.
- Replaces push-button, byte-at-a-time reading with an autonomous, handshaked bulk loader that has an inter-byte timeout and a programmable byte order.

---
 rtl/uart_word_loader.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/uart_word_loader.sv
// uart_word_loader
// Drains bytes from a UART RX FIFO, packs WB = WORD_W/8 of them into one
// word and writes DEPTH consecutive words to memory starting at address 0.
// The byte order is set by MSB_FIRST. A load is aborted with error/done set
// when the gap between two bytes of a load reaches TIMEOUT_CYC cycles
// (0 disables the timeout).
//
// Optional build macro: UART_WORD_LOADER_ECHO_EN
//   defined   - every popped byte is pushed to the TX FIFO in the same cycle,
//               and pops stall while tx_full is high.
//   undefined - wr_uart and w_data are held at 0 and tx_full is ignored.
module uart_word_loader #(
    parameter int WORD_W      = 16,
    parameter int ADDR_W      = 8,
    parameter int DEPTH       = 256,
    parameter int MSB_FIRST   = 1,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              rx_empty,
    input  logic [7:0]        r_data,
    output logic              rd_uart,
    input  logic              tx_full,
    output logic [7:0]        w_data,
    output logic              wr_uart,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   words_loaded
);

    localparam int WB    = WORD_W / 8;
    localparam int IDX_W = (WB > 1) ? $clog2(WB) : 1;
    localparam int WL_W  = ADDR_W + 1;
    localparam int TO_W  = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam bit TO_EN = (TIMEOUT_CYC > 0);

    localparam logic [WL_W-1:0]  DEPTH_L  = WL_W'(DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WB - 1);
    localparam logic [TO_W-1:0]  TO_LIMIT = TO_W'(TIMEOUT_CYC);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RECV  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              state_q;
    logic [IDX_W-1:0]    idx_q;
    logic [WORD_W-1:0]   word_q;
    logic [WORD_W-1:0]   word_d;
    logic [ADDR_W-1:0]   addr_q;
    logic [WL_W-1:0]     wl_q;
    logic                busy_q;
    logic                done_q;
    logic                error_q;
    logic                we_q;
    logic [TO_W-1:0]     to_cnt_q;
    logic                got_byte_q;
    logic                pop;
    logic                timeout_hit;
    logic [TO_W-1:0]     to_cnt_inc;
    logic [WL_W-1:0]     wl_inc;

    // Pop strobe and the echo path; the pop is combinational so a byte is
    // consumed in the same cycle the FIFO presents it.
`ifdef UART_WORD_LOADER_ECHO_EN
    assign pop     = (state_q == S_RECV) & ~rx_empty & ~tx_full;
    assign wr_uart = pop;
    assign w_data  = pop ? r_data : 8'h00;
`else
    logic unused_tx_full;
    assign unused_tx_full = tx_full;
    assign pop     = (state_q == S_RECV) & ~rx_empty;
    assign wr_uart = 1'b0;
    assign w_data  = 8'h00;
`endif

    assign rd_uart = pop;

    // Each byte slot of the word is loaded when the byte index selects it;
    // MSB_FIRST decides whether index 0 maps to the top or bottom slot.
    generate
        for (genvar gi = 0; gi < WB; gi++) begin : g_slot
            localparam int LSB = (MSB_FIRST != 0) ? 8 * (WB - 1 - gi) : 8 * gi;
            assign word_d[LSB +: 8] = (pop && (idx_q == IDX_W'(gi))) ? r_data
                                                                   : word_q[LSB +: 8];
        end
    endgenerate

    assign to_cnt_inc  = to_cnt_q + 1'b1;
    assign wl_inc      = wl_q + 1'b1;
    // Idle gap expires on the cycle the counter would reach the limit; a pop
    // in the same cycle takes precedence because this term requires ~pop.
    assign timeout_hit = TO_EN && got_byte_q && !pop && (to_cnt_inc == TO_LIMIT);

    // Load sequencer: byte collection, word write, timeout and completion.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            word_q     <= '0;
            addr_q     <= '0;
            wl_q       <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            we_q       <= 1'b0;
            to_cnt_q   <= '0;
            got_byte_q <= 1'b0;
        end else begin
            we_q   <= 1'b0;
            word_q <= word_d;
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_q    <= S_RECV;
                        busy_q     <= 1'b1;
                        done_q     <= 1'b0;
                        error_q    <= 1'b0;
                        wl_q       <= '0;
                        addr_q     <= '0;
                        idx_q      <= '0;
                        to_cnt_q   <= '0;
                        got_byte_q <= 1'b0;
                    end
                end
                S_RECV: begin
                    if (pop) begin
                        to_cnt_q   <= '0;
                        got_byte_q <= 1'b1;
                        if (idx_q == LAST_IDX) begin
                            idx_q   <= '0;
                            we_q    <= 1'b1;
                            state_q <= S_WRITE;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end else if (timeout_hit) begin
                        // Partial word is dropped: it is simply never written.
                        error_q <= 1'b1;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        idx_q   <= '0;
                        state_q <= S_DONE;
                    end else if (TO_EN && got_byte_q) begin
                        to_cnt_q <= to_cnt_inc;
                    end
                end
                S_WRITE: begin
                    wl_q <= wl_inc;
                    if (wl_inc == DEPTH_L) begin
                        // Last word: leave the address on DEPTH-1.
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_DONE;
                    end else begin
                        addr_q  <= addr_q + 1'b1;
                        state_q <= S_RECV;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign mem_we       = we_q;
    assign mem_addr     = addr_q;
    assign mem_wdata    = word_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign error        = error_q;
    assign words_loaded = wl_q;

endmodule
